seven_segment_capture: RTL and testbench

SEVEN_SEGMENT_CAPTURE -- requirements
Module: seven_segment_capture

---
 rtl/seg_pkg.sv | 36 +++
 rtl/seg_decode.sv | 32 +++
 rtl/seven_segment_capture.sv | 190 +++++++++++++++++++
 tb/tb_seven_segment_capture.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment capture block: segment patterns,
// digit strobe codes and the binary converter state encoding.
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] AN_ONES = 4'b1110;
  localparam logic [3:0] AN_TENS = 4'b1101;
  localparam logic [3:0] AN_HUND = 4'b1011;
  localparam logic [3:0] AN_THOU = 4'b0111;
  localparam logic [3:0] AN_NONE = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } conv_state_t;

  function automatic logic [15:0] mul10_add(
    input logic [15:0] acc,
    input logic [3:0]  d
  );
    return (acc << 3) + (acc << 1) + {12'd0, d};
  endfunction

endpackage

// File: rtl/seg_decode.sv
// Combinational segment decoder: active-low pattern -> {err, digit}.
// Ports: pattern[6:0] in; digit[3:0] out (4'hF if unknown); err out.
module seg_decode
  import seg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] digit,
  output logic       err
);

  always_comb begin
    digit = 4'hF;
    err   = 1'b0;
    unique case (1'b1)
      (pattern == SEG_0): digit = 4'd0;
      (pattern == SEG_1): digit = 4'd1;
      (pattern == SEG_2): digit = 4'd2;
      (pattern == SEG_3): digit = 4'd3;
      (pattern == SEG_4): digit = 4'd4;
      (pattern == SEG_5): digit = 4'd5;
      (pattern == SEG_6): digit = 4'd6;
      (pattern == SEG_7): digit = 4'd7;
      (pattern == SEG_8): digit = 4'd8;
      (pattern == SEG_9): digit = 4'd9;
      default: begin
        digit = 4'hF;
        err   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seven_segment_capture.sv
// Captures a multiplexed 4-digit seven-segment display into BCD frames.
// Ports: clk, rst_n (async low), seg[6:0], an[3:0] in; bcd[15:0],
// value[15:0], frame_valid, seg_err, overrun out.
// Macro SEG_BIN_CONV_EN builds the BCD-to-binary converter.
module seven_segment_capture
  import seg_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  output logic [15:0] bcd,
  output logic [15:0] value,
  output logic        frame_valid,
  output logic        seg_err,
  output logic        overrun
);

  localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);

  logic [6:0] seg_q, seg_p;
  logic [3:0] an_q, an_p;
  logic [3:0] cnt_q, cnt_d;
  logic       diff, sel_ok, cap, complete;
  logic [1:0] idx;

  logic [3:0] dec_digit;
  logic       dec_err;

  logic [3:0][3:0] slot_q, slot_m;
  logic [3:0]      err_q, err_m;
  logic [3:0]      seen_q, seen_m;

  seg_decode u_dec (
    .pattern (seg_q),
    .digit   (dec_digit),
    .err     (dec_err)
  );

  always_comb begin
    diff = {seg_q, an_q} != {seg_p, an_p};
    if (diff)
      cnt_d = 4'd0;
    else if (cnt_q == 4'd15)
      cnt_d = 4'd15;
    else
      cnt_d = cnt_q + 4'd1;
  end

  always_comb begin
    idx    = 2'd0;
    sel_ok = 1'b1;
    unique case (1'b1)
      (an_q == AN_ONES): idx = 2'd0;
      (an_q == AN_TENS): idx = 2'd1;
      (an_q == AN_HUND): idx = 2'd2;
      (an_q == AN_THOU): idx = 2'd3;
      default:           sel_ok = 1'b0;
    endcase
  end

  // A saturated count sitting on SETTLE must not recapture every cycle.
  always_comb begin
    cap = sel_ok && (cnt_d == SETTLE)
       && (diff || (cnt_q != SETTLE));
    slot_m = slot_q;
    err_m  = err_q;
    seen_m = seen_q;
    if (cap) begin
      slot_m[idx] = dec_digit;
      err_m[idx]  = dec_err;
      seen_m[idx] = 1'b1;
    end
    complete = cap && (&seen_m);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q  <= SEG_BLANK;
      an_q   <= AN_NONE;
      seg_p  <= SEG_BLANK;
      an_p   <= AN_NONE;
      cnt_q  <= 4'd0;
      slot_q <= '0;
      err_q  <= '0;
      seen_q <= '0;
    end else begin
      seg_q  <= seg;
      an_q   <= an;
      seg_p  <= seg_q;
      an_p   <= an_q;
      cnt_q  <= cnt_d;
      slot_q <= slot_m;
      err_q  <= err_m;
      seen_q <= complete ? 4'd0 : seen_m;
    end
  end

`ifdef SEG_BIN_CONV_EN

  conv_state_t state_q, state_d;
  logic [1:0]  step_q;
  logic [15:0] acc_q, acc_d;
  logic [15:0] fbcd_q;
  logic        ferr_q;
  logic [3:0]  conv_digit;
  logic        last_step;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (complete) state_d = CONV;
      CONV:    if (step_q == 2'd3) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Thousands digit first so acc*10+d builds the value MSD-down.
  always_comb begin
    conv_digit = fbcd_q[15:12];
    unique case (step_q)
      2'd0: conv_digit = fbcd_q[15:12];
      2'd1: conv_digit = fbcd_q[11:8];
      2'd2: conv_digit = fbcd_q[7:4];
      2'd3: conv_digit = fbcd_q[3:0];
      default: conv_digit = fbcd_q[3:0];
    endcase
    acc_d     = mul10_add(acc_q, conv_digit);
    last_step = (state_q == CONV) && (step_q == 2'd3);
  end

  assign overrun = complete && (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      step_q      <= 2'd0;
      acc_q       <= '0;
      fbcd_q      <= '0;
      ferr_q      <= 1'b0;
      bcd         <= '0;
      value       <= '0;
      seg_err     <= 1'b0;
      frame_valid <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_valid <= last_step;
      if ((state_q == IDLE) && complete) begin
        fbcd_q <= slot_m;
        ferr_q <= |err_m;
        acc_q  <= '0;
        step_q <= 2'd0;
      end
      if (state_q == CONV) begin
        acc_q  <= acc_d;
        step_q <= step_q + 2'd1;
      end
      if (last_step) begin
        bcd     <= fbcd_q;
        seg_err <= ferr_q;
        value   <= ferr_q ? 16'hFFFF : acc_d;
      end
    end
  end

`else

  assign value   = '0;
  assign overrun = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd         <= '0;
      seg_err     <= 1'b0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= complete;
      if (complete) begin
        bcd     <= slot_m;
        seg_err <= |err_m;
      end
    end
  end

`endif

endmodule

// File: tb/tb_seven_segment_capture.sv
// Directed bench for seven_segment_capture: SETTLE=0 and SETTLE=1 copies
// share stimulus; adapts expectations to SEG_BIN_CONV_EN.
module tb_seven_segment_capture;
  import seg_pkg::*;

`ifdef SEG_BIN_CONV_EN
  localparam int LAT = 5;
  localparam bit CONV_ON = 1'b1;
`else
  localparam int LAT = 1;
  localparam bit CONV_ON = 1'b0;
`endif

  logic        clk, rst_n;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [15:0] bcd0, value0, bcd1, value1;
  logic        fv0, err0, ov0, fv1, err1, ov1;

  seven_segment_capture #(.SETTLE_CYCLES(0)) u0 (
    .clk(clk), .rst_n(rst_n), .seg(seg), .an(an),
    .bcd(bcd0), .value(value0), .frame_valid(fv0),
    .seg_err(err0), .overrun(ov0)
  );

  seven_segment_capture #(.SETTLE_CYCLES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .seg(seg), .an(an),
    .bcd(bcd1), .value(value1), .frame_valid(fv1),
    .seg_err(err1), .overrun(ov1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int f0, f1, o0, o1, fv_cyc0;
  logic [15:0] lb0, lv0, lb1, lv1;
  logic        le0, le1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (fv0) begin
      f0++; lb0 = bcd0; lv0 = value0; le0 = err0; fv_cyc0 = cyc;
    end
    if (fv1) begin
      f1++; lb1 = bcd1; lv1 = value1; le1 = err1;
    end
    if (ov0) o0++;
    if (ov1) o1++;
  end

  typedef struct {
    logic [3:0][6:0] p;
    int              dwell;
    logic [15:0]     bcd;
    logic            err;
    logic [15:0]     val;
    int              nf1;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] an_of(input int k);
    logic [3:0] one;
    one = 4'b0001 << k;
    return ~one;
  endfunction

  task automatic drive(input logic [6:0] p, input logic [3:0] a,
                       input int n);
    seg = p;
    an  = a;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drive(SEG_BLANK, AN_NONE, n);
  endtask

  task automatic clr();
    f0 = 0; f1 = 0; o0 = 0; o1 = 0; fv_cyc0 = -1;
  endtask

  initial begin
    logic [15:0] ev;
    int dc;
    clk = 0; rst_n = 0; seg = SEG_BLANK; an = AN_NONE;
    clr();
    repeat (2) @(posedge clk);
    #1;
    check("rst_bcd", 32'(bcd0), 32'h0);
    check("rst_value", 32'(value0), 32'h0);
    check("rst_fv", 32'(fv0), 32'h0);
    check("rst_err", 32'(err0), 32'h0);
    check("rst_ovr", 32'(ov0), 32'h0);
    rst_n = 1;
    idle(3);

    vecs[0] = '{p:{SEG_1,SEG_2,SEG_3,SEG_4}, dwell:3,
                bcd:16'h1234, err:0, val:16'd1234, nf1:1};
    vecs[1] = '{p:{SEG_9,SEG_9,SEG_9,SEG_9}, dwell:1,
                bcd:16'h9999, err:0, val:16'd9999, nf1:0};
    vecs[2] = '{p:{SEG_0,SEG_0,SEG_0,SEG_0}, dwell:2,
                bcd:16'h0000, err:0, val:16'd0, nf1:1};
    vecs[3] = '{p:{SEG_5,SEG_6,SEG_7,SEG_8}, dwell:1,
                bcd:16'h5678, err:0, val:16'd5678, nf1:0};
    vecs[4] = '{p:{SEG_8,SEG_0,SEG_2,SEG_BLANK}, dwell:2,
                bcd:16'h802F, err:1, val:16'hFFFF, nf1:1};
    vecs[5] = '{p:{SEG_3,SEG_1,7'b0101010,SEG_9}, dwell:3,
                bcd:16'h31F9, err:1, val:16'hFFFF, nf1:1};

    for (int i = 0; i < 6; i++) begin
      clr();
      for (int k = 3; k >= 0; k--)
        drive(vecs[i].p[k], an_of(k), vecs[i].dwell);
      idle(10);
      ev = CONV_ON ? vecs[i].val : 16'h0;
      check($sformatf("v%0d_frames0", i), 32'(f0), 32'd1);
      check($sformatf("v%0d_bcd0", i), 32'(lb0), 32'(vecs[i].bcd));
      check($sformatf("v%0d_err0", i), 32'(le0), 32'(vecs[i].err));
      check($sformatf("v%0d_val0", i), 32'(lv0), 32'(ev));
      check($sformatf("v%0d_frames1", i), 32'(f1), 32'(vecs[i].nf1));
      if (vecs[i].nf1 == 1) begin
        check($sformatf("v%0d_bcd1", i), 32'(lb1), 32'(vecs[i].bcd));
        check($sformatf("v%0d_val1", i), 32'(lv1), 32'(ev));
      end
    end

    // Multi-low strobe in the middle of a frame is ignored.
    clr();
    drive(SEG_1, AN_THOU, 2);
    drive(SEG_2, AN_HUND, 2);
    drive(SEG_5, 4'b0011, 5);
    drive(SEG_3, AN_TENS, 2);
    drive(SEG_4, AN_ONES, 2);
    idle(10);
    check("multi_frames0", 32'(f0), 32'd1);
    check("multi_bcd0", 32'(lb0), 32'h1234);
    check("multi_frames1", 32'(f1), 32'd1);
    check("multi_bcd1", 32'(lb1), 32'h1234);

    // Out-of-order arrival with an overwritten (bad then good) ones slot.
    clr();
    drive(SEG_BLANK, AN_ONES, 2);
    drive(SEG_1, AN_THOU, 2);
    drive(SEG_2, AN_HUND, 2);
    drive(SEG_4, AN_ONES, 2);
    drive(SEG_3, AN_TENS, 2);
    idle(10);
    check("ovw_frames0", 32'(f0), 32'd1);
    check("ovw_bcd0", 32'(lb0), 32'h1234);
    check("ovw_err0", 32'(le0), 32'h0);
    check("ovw_bcd1", 32'(lb1), 32'h1234);

    // Completion-to-frame_valid latency.
    clr();
    drive(SEG_4, AN_THOU, 1);
    drive(SEG_3, AN_HUND, 1);
    drive(SEG_2, AN_TENS, 1);
    dc = cyc;
    drive(SEG_1, AN_ONES, 1);
    idle(10);
    check("lat_frames0", 32'(f0), 32'd1);
    check("lat_cycle0", 32'(fv_cyc0), 32'(dc + 1 + LAT));
    check("lat_bcd0", 32'(lb0), 32'h4321);

    // Back-to-back frames every 4 cycles on the SETTLE=0 copy.
    clr();
    drive(SEG_1, AN_THOU, 1); drive(SEG_1, AN_HUND, 1);
    drive(SEG_1, AN_TENS, 1); drive(SEG_1, AN_ONES, 1);
    drive(SEG_2, AN_THOU, 1); drive(SEG_2, AN_HUND, 1);
    drive(SEG_2, AN_TENS, 1); drive(SEG_2, AN_ONES, 1);
    drive(SEG_3, AN_THOU, 1); drive(SEG_3, AN_HUND, 1);
    drive(SEG_3, AN_TENS, 1); drive(SEG_3, AN_ONES, 1);
    drive(SEG_4, AN_THOU, 1); drive(SEG_4, AN_HUND, 1);
    drive(SEG_4, AN_TENS, 1); drive(SEG_4, AN_ONES, 1);
    idle(12);
    check("b2b_frames0", 32'(f0), CONV_ON ? 32'd2 : 32'd4);
    check("b2b_bcd0", 32'(lb0), CONV_ON ? 32'h3333 : 32'h4444);
    check("b2b_ovr0", 32'(o0), CONV_ON ? 32'd2 : 32'd0);
    check("b2b_val0", 32'(lv0), CONV_ON ? 32'd3333 : 32'd0);
    check("b2b_frames1", 32'(f1), 32'd0);
    check("b2b_ovr1", 32'(o1), 32'd0);

    // Reset with three digits pending discards them.
    clr();
    drive(SEG_9, AN_THOU, 2);
    drive(SEG_9, AN_HUND, 2);
    drive(SEG_9, AN_TENS, 2);
    #2 rst_n = 0;
    #1;
    check("async_bcd0", 32'(bcd0), 32'h0);
    check("async_bcd1", 32'(bcd1), 32'h0);
    @(posedge clk);
    #1 rst_n = 1;
    drive(SEG_7, AN_ONES, 2);
    idle(8);
    check("rst_partial0", 32'(f0), 32'd0);
    check("rst_partial1", 32'(f1), 32'd0);
    drive(SEG_0, AN_THOU, 2);
    drive(SEG_0, AN_HUND, 2);
    drive(SEG_0, AN_TENS, 2);
    idle(10);
    check("rst_frames0", 32'(f0), 32'd1);
    check("rst_bcd0", 32'(lb0), 32'h0007);
    check("rst_frames1", 32'(f1), 32'd1);
    check("rst_bcd1", 32'(lb1), 32'h0007);
    check("rst_val0", 32'(lv0), CONV_ON ? 32'd7 : 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
